// File: rtl/control_multiciclo.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute states and drives datapath enables.
// Latency: outputs are combinational from the current state; one state transition per Clk edge.
// Backpressure: memory states stall on MemReady=0 and fault after TIMEOUT stalled cycles.
module control_multiciclo #(
   parameter int TIMEOUT = 15
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic [5:0] OpCode,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCEn,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemToWrite,
   output logic       IRWrite,
   output logic       MemToReg,
   output logic       RegDst,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [2:0] ALUOp,
   output logic [3:0] State,
   output logic       Error
);

   localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      RWB    = 4'd7,
      BRANCH = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
      JUMP   = 4'd11,
      FAULT  = 4'd12
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] wait_cnt;
   logic          wait_st;
   logic          timed_out;

   // Only the three memory-handshake states count stalled cycles.
   assign wait_st   = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
   // A late MemReady in the final allowed cycle still completes, so require it low.
   assign timed_out = (wait_cnt == TMAX) && !MemReady;
   assign State     = state;

   // State register; reset abandons any instruction and restarts at FETCH.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= FETCH;
      end else begin
         state <= next_state;
      end
   end

   // Stall counter: counts consecutive not-ready cycles within one memory state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         wait_cnt <= '0;
      end else if ((next_state != state) || MemReady) begin
         wait_cnt <= '0;
      end else if (wait_st) begin
         wait_cnt <= wait_cnt + CW'(1);
      end
   end

   // Next-state decode and per-state datapath controls; reset masks every output.
   always_comb begin
      next_state = state;
      PCEn       = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemToWrite = 1'b0;
      IRWrite    = 1'b0;
      MemToReg   = 1'b0;
      RegDst     = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      PCSrc      = 2'b00;
      ALUOp      = 3'b000;
      Error      = 1'b0;

      case (state)
         FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            if (MemReady) begin
               IRWrite    = 1'b1;
               PCEn       = 1'b1;
               next_state = DECODE;
            end else if (timed_out) begin
               next_state = FAULT;
            end
         end
         DECODE: begin
            ALUSrcB = 2'b11;
            case (OpCode)
               OP_RTYPE:      next_state = EXEC;
               OP_LW, OP_SW:  next_state = MEMADR;
               OP_BEQ:        next_state = BRANCH;
               OP_ADDI:       next_state = ADDIEX;
               OP_J:          next_state = JUMP;
               default:       next_state = FAULT;
            endcase
         end
         MEMADR: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            next_state = (OpCode == OP_SW) ? MEMWR : MEMRD;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            if (MemReady) begin
               next_state = MEMWB;
            end else if (timed_out) begin
               next_state = FAULT;
            end
         end
         MEMWB: begin
            RegWrite   = 1'b1;
            MemToReg   = 1'b1;
            next_state = FETCH;
         end
         MEMWR: begin
            MemToWrite = 1'b1;
            IorD       = 1'b1;
            if (MemReady) begin
               next_state = FETCH;
            end else if (timed_out) begin
               next_state = FAULT;
            end
         end
         EXEC: begin
            ALUSrcA    = 1'b1;
            ALUOp      = 3'b010;
            next_state = RWB;
         end
         RWB: begin
            RegWrite   = 1'b1;
            RegDst     = 1'b1;
            next_state = FETCH;
         end
         BRANCH: begin
            ALUSrcA    = 1'b1;
            ALUOp      = 3'b001;
            PCSrc      = 2'b01;
            PCEn       = Zero;
            next_state = FETCH;
         end
         ADDIEX: begin
            ALUSrcA    = 1'b1;
            ALUSrcB    = 2'b10;
            next_state = ADDIWB;
         end
         ADDIWB: begin
            RegWrite   = 1'b1;
            next_state = FETCH;
         end
         JUMP: begin
            PCSrc      = 2'b10;
            PCEn       = 1'b1;
            next_state = FETCH;
         end
         FAULT: begin
            Error      = 1'b1;
            next_state = FAULT;
         end
         default: begin
            next_state = FAULT;
         end
      endcase

      if (Reset) begin
         PCEn       = 1'b0;
         IorD       = 1'b0;
         MemRead    = 1'b0;
         MemToWrite = 1'b0;
         IRWrite    = 1'b0;
         MemToReg   = 1'b0;
         RegDst     = 1'b0;
         RegWrite   = 1'b0;
         ALUSrcA    = 1'b0;
         ALUSrcB    = 2'b00;
         PCSrc      = 2'b00;
         ALUOp      = 3'b000;
         Error      = 1'b0;
      end
   end

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed testbench for control_multiciclo: instruction sequences, stalls, timeout and reset.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: MemReady driven directly from stimulus.
module tb_control_multiciclo;

   logic       Clk;
   logic       Reset;
   logic [5:0] OpCode;
   logic       Zero;
   logic       MemReady;
   logic       PCEn, IorD, MemRead, MemToWrite, IRWrite;
   logic       MemToReg, RegDst, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc;
   logic [2:0] ALUOp;
   logic [3:0] State;
   logic       Error;

   int n_checks = 0;
   int n_fail   = 0;

   control_multiciclo #(.TIMEOUT(15)) dut (
      .Clk(Clk), .Reset(Reset), .OpCode(OpCode), .Zero(Zero), .MemReady(MemReady),
      .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead), .MemToWrite(MemToWrite),
      .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUOp(ALUOp),
      .State(State), .Error(Error)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Checks the write-type enables that must all be low in a given context.
   task automatic check_quiet(input string tag);
      check({tag, "_pcen"},  8'(PCEn),       8'd0);
      check({tag, "_irw"},   8'(IRWrite),    8'd0);
      check({tag, "_regw"},  8'(RegWrite),   8'd0);
      check({tag, "_memw"},  8'(MemToWrite), 8'd0);
      check({tag, "_memr"},  8'(MemRead),    8'd0);
   endtask

   initial begin
      Reset = 1'b1; OpCode = 6'b000000; Zero = 1'b0; MemReady = 1'b1;
      tick(); tick();

      // Reset state: FETCH, no error, all enables held low
      check("rst_state", 8'(State), 8'd0);
      check("rst_error", 8'(Error), 8'd0);
      check_quiet("rst");
      Reset = 1'b0;
      #1;

      // R-type: 0,1,6,7,0
      check("r_fetch_st",   8'(State),   8'd0);
      check("r_fetch_memr", 8'(MemRead), 8'd1);
      check("r_fetch_irw",  8'(IRWrite), 8'd1);
      check("r_fetch_pcen", 8'(PCEn),    8'd1);
      check("r_fetch_srcb", 8'(ALUSrcB), 8'd1);
      check("r_fetch_regw", 8'(RegWrite), 8'd0);
      tick();
      check("r_dec_st",   8'(State),   8'd1);
      check("r_dec_srcb", 8'(ALUSrcB), 8'd3);
      check("r_dec_regw", 8'(RegWrite), 8'd0);
      tick();
      check("r_exec_st",   8'(State),   8'd6);
      check("r_exec_aluop", 8'(ALUOp),  8'd2);
      check("r_exec_srca", 8'(ALUSrcA), 8'd1);
      check("r_exec_srcb", 8'(ALUSrcB), 8'd0);
      check("r_exec_regw", 8'(RegWrite), 8'd0);
      tick();
      check("r_rwb_st",   8'(State),    8'd7);
      check("r_rwb_regw", 8'(RegWrite), 8'd1);
      check("r_rwb_dst",  8'(RegDst),   8'd1);
      check("r_rwb_m2r",  8'(MemToReg), 8'd0);
      tick();
      check("r_back_st", 8'(State), 8'd0);

      // lw with 3 stall cycles in MEMRD: 0,1,2,3,3,3,3,4,0
      OpCode = 6'b100011;
      tick();
      check("lw_dec_st", 8'(State), 8'd1);
      tick();
      check("lw_adr_st",   8'(State),   8'd2);
      check("lw_adr_srcb", 8'(ALUSrcB), 8'd2);
      check("lw_adr_srca", 8'(ALUSrcA), 8'd1);
      MemReady = 1'b0;
      tick();
      for (int i = 0; i < 3; i++) begin
         check("lw_rd_st",   8'(State),   8'd3);
         check("lw_rd_memr", 8'(MemRead), 8'd1);
         check("lw_rd_iord", 8'(IorD),    8'd1);
         tick();
      end
      check("lw_rd4_st", 8'(State), 8'd3);
      MemReady = 1'b1;
      #1;
      check("lw_rd4_memr", 8'(MemRead), 8'd1);
      check("lw_rd4_iord", 8'(IorD),    8'd1);
      tick();
      check("lw_wb_st",   8'(State),    8'd4);
      check("lw_wb_regw", 8'(RegWrite), 8'd1);
      check("lw_wb_m2r",  8'(MemToReg), 8'd1);
      check("lw_wb_dst",  8'(RegDst),   8'd0);
      check("lw_wb_memw", 8'(MemToWrite), 8'd0);
      tick();
      check("lw_back_st", 8'(State), 8'd0);

      // beq taken, then not taken
      OpCode = 6'b000100; Zero = 1'b1;
      tick(); tick();
      check("beq1_st",    8'(State), 8'd8);
      check("beq1_pcen",  8'(PCEn),  8'd1);
      check("beq1_pcsrc", 8'(PCSrc), 8'd1);
      check("beq1_aluop", 8'(ALUOp), 8'd1);
      tick();
      check("beq1_back", 8'(State), 8'd0);
      Zero = 1'b0;
      tick(); tick();
      check("beq0_st",    8'(State), 8'd8);
      check("beq0_pcen",  8'(PCEn),  8'd0);
      check("beq0_pcsrc", 8'(PCSrc), 8'd1);
      tick();
      check("beq0_back", 8'(State), 8'd0);

      // addi: 0,1,9,10,0
      OpCode = 6'b001000;
      tick(); tick();
      check("addi_ex_st",   8'(State),   8'd9);
      check("addi_ex_srcb", 8'(ALUSrcB), 8'd2);
      tick();
      check("addi_wb_st",   8'(State),    8'd10);
      check("addi_wb_regw", 8'(RegWrite), 8'd1);
      check("addi_wb_dst",  8'(RegDst),   8'd0);
      tick();
      check("addi_back", 8'(State), 8'd0);

      // j: 0,1,11,0
      OpCode = 6'b000010;
      tick(); tick();
      check("j_st",    8'(State), 8'd11);
      check("j_pcen",  8'(PCEn),  8'd1);
      check("j_pcsrc", 8'(PCSrc), 8'd2);
      tick();
      check("j_back", 8'(State), 8'd0);

      // sw: 0,1,2,5,0
      OpCode = 6'b101011;
      tick(); tick(); tick();
      check("sw_st",   8'(State),      8'd5);
      check("sw_memw", 8'(MemToWrite), 8'd1);
      check("sw_iord", 8'(IorD),       8'd1);
      check("sw_regw", 8'(RegWrite),   8'd0);
      tick();
      check("sw_back", 8'(State), 8'd0);

      // sw stalled in MEMWR, Reset pulsed mid-cycle drops MemToWrite at once
      tick(); tick();
      MemReady = 1'b0;
      tick();
      check("swr_st",   8'(State),      8'd5);
      check("swr_memw", 8'(MemToWrite), 8'd1);
      #2;
      Reset = 1'b1;
      #1;
      check("swr_async_memw", 8'(MemToWrite), 8'd0);
      check("swr_async_st",   8'(State),      8'd0);
      tick();
      Reset = 1'b0;
      #1;
      check("swr_rel_st", 8'(State), 8'd0);

      // Late MemReady at the last allowed FETCH cycle completes normally
      OpCode = 6'b000000;
      for (int i = 0; i < 15; i++) tick();
      check("tmo_edge_st",  8'(State),   8'd0);
      check("tmo_edge_irw", 8'(IRWrite), 8'd0);
      MemReady = 1'b1;
      tick();
      check("tmo_edge_dec", 8'(State), 8'd1);
      tick(); tick(); tick();
      check("tmo_edge_back", 8'(State), 8'd0);

      // Timeout in FETCH: 16 cycles then FAULT
      MemReady = 1'b0;
      for (int i = 0; i < 15; i++) tick();
      check("tmo_last_fetch", 8'(State), 8'd0);
      tick();
      check("tmo_fault_st",  8'(State), 8'd12);
      check("tmo_fault_err", 8'(Error), 8'd1);
      check_quiet("tmo_fault");
      MemReady = 1'b1;
      tick(); tick();
      check("tmo_stay_st",  8'(State), 8'd12);
      check("tmo_stay_err", 8'(Error), 8'd1);
      Reset = 1'b1;
      #1;
      check("tmo_rst_st",  8'(State), 8'd0);
      check("tmo_rst_err", 8'(Error), 8'd0);
      tick();
      Reset = 1'b0;
      #1;

      // Illegal opcode in DECODE -> FAULT
      OpCode = 6'b111111;
      tick();
      check("ill_dec_st", 8'(State), 8'd1);
      tick();
      check("ill_st",  8'(State), 8'd12);
      check("ill_err", 8'(Error), 8'd1);
      check_quiet("ill");
      tick(); tick();
      check("ill_hold_st", 8'(State), 8'd12);
      check_quiet("ill_hold");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/control_multiciclo.md
CONTROL_MULTICICLO -- requirements
Module: control_multiciclo

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum wait cycles for MemReady in any memory state before fault.
REQ-002 SHALL have port Clk  in  1  single system clock; all state updates occur on the rising edge.
REQ-003 SHALL have port Reset  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port OpCode  in  6  instruction register bits [31:26].
REQ-005 SHALL have port Zero  in  1  ALU zero flag.
REQ-006 SHALL have port MemReady  in  1  shared memory access-complete handshake.
REQ-007 SHALL have outputs PCEn, IorD, MemRead, MemToWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA  out  1 each  datapath enables and mux selects.
REQ-008 SHALL have outputs ALUSrcB  out  2 (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2) and PCSrc  out  2 (00 ALU result, 01 ALUOut, 10 jump target).
REQ-009 SHALL have output ALUOp  out  3: 000 add, 001 sub, 010 decode Funct.
REQ-010 SHALL have outputs State  out  4 (current state code) and Error  out  1 (sticky fault flag).

Function
REQ-011 SHALL implement the following states and codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11, FAULT=12.
REQ-012 SHALL drive every output not listed for a state at 0.
REQ-013 FETCH SHALL set MemRead=1, IorD=0, ALUSrcB=01, ALUOp=000; IRWrite=1 and PCEn=1 (PCSrc=00) only in the cycle MemReady=1, then go to DECODE; otherwise it SHALL stay in FETCH.
REQ-014 DECODE SHALL set ALUSrcB=11, ALUOp=000, and branch on OpCode: 000000 to EXEC, 100011/101011 to MEMADR, 000100 to BRANCH, 001000 to ADDIEX, 000010 to JUMP, any other value to FAULT.
REQ-015 MEMADR SHALL set ALUSrcA=1, ALUSrcB=10, ALUOp=000, and go to MEMRD for lw or to MEMWR for sw.
REQ-016 MEMRD SHALL set MemRead=1, IorD=1, go to MEMWB on MemReady=1, and otherwise wait.
REQ-017 MEMWB SHALL set RegWrite=1, MemToReg=1, RegDst=0, and go to FETCH.
REQ-018 MEMWR SHALL set MemToWrite=1, IorD=1, go to FETCH on MemReady=1, and otherwise wait.
REQ-019 EXEC SHALL set ALUSrcA=1, ALUSrcB=00, ALUOp=010, and go to RWB; RWB SHALL set RegWrite=1, RegDst=1, MemToReg=0, and go to FETCH.
REQ-020 BRANCH SHALL set ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSrc=01, PCEn=Zero, and go to FETCH.
REQ-021 ADDIEX SHALL set ALUSrcA=1, ALUSrcB=10, ALUOp=000, and go to ADDIWB; ADDIWB SHALL set RegWrite=1, RegDst=0, MemToReg=0, and go to FETCH.
REQ-022 JUMP SHALL set PCSrc=10, PCEn=1, and go to FETCH.
REQ-023 SHALL keep a wait counter of width $clog2(TIMEOUT+1) that increments each cycle spent in FETCH/MEMRD/MEMWR with MemReady=0, and clears on any state change or on MemReady=1.
REQ-024 SHALL enter FAULT when the wait counter equals TIMEOUT and MemReady=0; MemReady=1 in that same cycle SHALL take precedence, completing normally.
REQ-025 FAULT SHALL drive all enables 0, set Error=1, and remain in FAULT until Reset.
REQ-026 SHALL take these cycle counts with MemReady tied high: R-type 4, lw 5, sw 4, beq 3, addi 4, j 3.
REQ-027 MemToWrite and RegWrite SHALL never be 1 in the same cycle, and IRWrite SHALL be 1 only in FETCH.

Reset
REQ-028 Reset=1 SHALL immediately force State=FETCH, wait counter=0, Error=0, and hold PCEn, IRWrite, RegWrite, MemToWrite, MemRead at 0 while asserted.
REQ-029 Reset asserted mid-instruction, including in a wait state or FAULT, SHALL abandon the instruction with no further writes.
REQ-030 After Reset deassertion, the first rising edge SHALL evaluate FETCH normally.

Verification
REQ-031 SHALL cover: R-type (OpCode 000000), MemReady=1 -> State sequence 0,1,6,7,0; RegWrite=1 with RegDst=1 only in state 7.
REQ-032 SHALL cover: lw (100011) with MemReady low 3 cycles in MEMRD -> sequence 0,1,2,3,3,3,3,4,0; MemRead=1, IorD=1 throughout state 3.
REQ-033 SHALL cover: beq (000100) with Zero=1, then with Zero=0 -> PCEn=1 / PCEn=0 in state 8, PCSrc=01 in both.
REQ-034 SHALL cover: TIMEOUT=15, MemReady held 0 in FETCH -> FAULT (State=12) after 16 FETCH cycles with Error=1; Reset -> State=0, Error=0.
REQ-035 SHALL cover: OpCode 111111 in DECODE -> FAULT, Error=1, all enables 0 thereafter.
REQ-036 SHALL cover: Reset pulsed during MEMWR -> MemToWrite drops to 0 asynchronously, State=0 on release.
